trap_controller: RTL and testbench

- Multi-cycle sequencer that decides when the core enters and leaves machine-mode traps.
- Sits between the execute stage and the machine CSR file.
- Takes exception flags, pending interrupts and MRET from execute, and picks one trap cause by fixed priority.
- Strobes the CSR file to save or restore state, then stalls, flushes and redirects the PC to the mtvec target or to mepc.

---
 rtl/trap_controller.sv | 150 +++++++++++++++
 tb/tb_trap_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: picks one trap cause by fixed priority, strobes the
// CSR file to save or restore state, then flushes and redirects the PC.
module trap_controller #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            illegal_instruction_in,
  input  logic            ecall_in,
  input  logic            ebreak_in,
  input  logic            misaligned_in,
  input  logic [XLEN-1:0] fault_addr_in,
  input  logic            mret_in,
  input  logic            mstatus_mie_in,
  input  logic [11:0]     mie_in,
  input  logic [11:0]     mip_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            stall_out,
  output logic            flush_out,
  output logic            pc_redirect_valid_out,
  output logic [XLEN-1:0] pc_redirect_out,
  output logic            trap_we_out,
  output logic [XLEN-1:0] mepc_wdata_out,
  output logic [XLEN-1:0] mcause_wdata_out,
  output logic [XLEN-1:0] mtval_wdata_out,
  output logic            mret_we_out,
  output logic            busy_out
);

  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    REDIRECT = 2'd2,
    RETURN   = 2'd3
  } state_t;

  state_t state;

  logic [11:0]       int_bits;
  logic              int_pend;
  logic              exc_any;
  logic              take_trap;
  logic              take_mret;
  logic [CODE_W-1:0] int_code;
  logic [CODE_W-1:0] exc_code;
  logic [CODE_W-1:0] sel_code;
  logic [XLEN-1:0]   sel_tval;
  logic [XLEN-1:0]   sel_cause;
  logic              stall_q;
  logic [XLEN-1:0]   vec_base;
  logic [XLEN-1:0]   vec_off;
  logic              unused_bits;

  // Only MEI/MSI/MTI are implemented; the remaining mie/mip bits are don't-care.
  assign int_bits  = mie_in & mip_in;
  assign int_pend  = mstatus_mie_in & (int_bits[11] | int_bits[3] | int_bits[7]);
  assign exc_any   = misaligned_in | illegal_instruction_in | ecall_in | ebreak_in;
  assign take_trap = instr_valid_in & (int_pend | exc_any);
  assign take_mret = instr_valid_in & mret_in & ~(int_pend | exc_any);

  assign unused_bits = ^{int_bits[10:8], int_bits[6:4], int_bits[2:0], mepc_in[0]};

  // Fixed-priority cause selection; interrupts beat exceptions.
  always_comb begin
    int_code = CODE_W'(0);
    exc_code = CODE_W'(0);
    if (int_bits[11])     int_code = CODE_W'(11);
    else if (int_bits[3]) int_code = CODE_W'(3);
    else if (int_bits[7]) int_code = CODE_W'(7);
    if (misaligned_in)               exc_code = CODE_W'(0);
    else if (illegal_instruction_in) exc_code = CODE_W'(2);
    else if (ecall_in)               exc_code = CODE_W'(11);
    else if (ebreak_in)              exc_code = CODE_W'(3);
  end

  always_comb begin
    sel_code  = int_pend ? int_code : exc_code;
    sel_cause = {int_pend, {(XLEN-CODE_W-1){1'b0}}, sel_code};
    sel_tval  = (!int_pend && misaligned_in) ? fault_addr_in : '0;
  end

  // Sequencer; strobes and control outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      stall_q               <= 1'b0;
      flush_out             <= 1'b0;
      pc_redirect_valid_out <= 1'b0;
      trap_we_out           <= 1'b0;
      mret_we_out           <= 1'b0;
      mepc_wdata_out        <= '0;
      mcause_wdata_out      <= '0;
      mtval_wdata_out       <= '0;
    end else begin
      stall_q               <= 1'b0;
      flush_out             <= 1'b0;
      pc_redirect_valid_out <= 1'b0;
      trap_we_out           <= 1'b0;
      mret_we_out           <= 1'b0;
      case (state)
        IDLE: begin
          if (take_trap) begin
            state            <= SAVE;
            mepc_wdata_out   <= pc_in;
            mcause_wdata_out <= sel_cause;
            mtval_wdata_out  <= sel_tval;
            trap_we_out      <= 1'b1;
            stall_q          <= 1'b1;
          end else if (take_mret) begin
            state                 <= RETURN;
            mret_we_out           <= 1'b1;
            pc_redirect_valid_out <= 1'b1;
            flush_out             <= 1'b1;
            stall_q               <= 1'b1;
          end
        end
        SAVE: begin
          state                 <= REDIRECT;
          pc_redirect_valid_out <= 1'b1;
          flush_out             <= 1'b1;
          stall_q               <= 1'b1;
        end
        REDIRECT: state <= IDLE;
        RETURN:   state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Detect cycle stalls combinationally so execute cannot retire the trapping instruction.
  assign stall_out = stall_q | (reset & (state == IDLE) & (take_trap | take_mret));
  assign busy_out  = (state != IDLE);

  // Targets read mtvec/mepc live, so they reflect any CSR update made during SAVE.
  assign vec_base = {mtvec_in[XLEN-1:2], 2'b00};
  assign vec_off  = (mtvec_in[1:0] == 2'b01 && mcause_wdata_out[XLEN-1])
                    ? XLEN'({mcause_wdata_out[CODE_W-1:0], 2'b00}) : '0;

  always_comb begin
    pc_redirect_out = '0;
    if (state == REDIRECT)    pc_redirect_out = vec_base + vec_off;
    else if (state == RETURN) pc_redirect_out = {mepc_in[XLEN-1:1], 1'b0};
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: per-cycle expectations queued at stimulus time
// and popped/compared once the DUT reaches each cycle.
module tb_trap_controller;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic            instr_valid_in;
  logic [XLEN-1:0] pc_in;
  logic            illegal_instruction_in;
  logic            ecall_in;
  logic            ebreak_in;
  logic            misaligned_in;
  logic [XLEN-1:0] fault_addr_in;
  logic            mret_in;
  logic            mstatus_mie_in;
  logic [11:0]     mie_in;
  logic [11:0]     mip_in;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic            stall_out;
  logic            flush_out;
  logic            pc_redirect_valid_out;
  logic [XLEN-1:0] pc_redirect_out;
  logic            trap_we_out;
  logic [XLEN-1:0] mepc_wdata_out;
  logic [XLEN-1:0] mcause_wdata_out;
  logic [XLEN-1:0] mtval_wdata_out;
  logic            mret_we_out;
  logic            busy_out;

  trap_controller #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .instr_valid_in(instr_valid_in), .pc_in(pc_in),
    .illegal_instruction_in(illegal_instruction_in), .ecall_in(ecall_in),
    .ebreak_in(ebreak_in), .misaligned_in(misaligned_in),
    .fault_addr_in(fault_addr_in), .mret_in(mret_in),
    .mstatus_mie_in(mstatus_mie_in), .mie_in(mie_in), .mip_in(mip_in),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .stall_out(stall_out), .flush_out(flush_out),
    .pc_redirect_valid_out(pc_redirect_valid_out), .pc_redirect_out(pc_redirect_out),
    .trap_we_out(trap_we_out), .mepc_wdata_out(mepc_wdata_out),
    .mcause_wdata_out(mcause_wdata_out), .mtval_wdata_out(mtval_wdata_out),
    .mret_we_out(mret_we_out), .busy_out(busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        trap_we, mret_we, rv, flush, stall, busy, chk_data;
    logic [31:0] pc, mepc, mcause, mtval;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid_in = 0; illegal_instruction_in = 0; ecall_in = 0; ebreak_in = 0;
    misaligned_in = 0; mret_in = 0; mstatus_mie_in = 0; mie_in = '0; mip_in = '0;
    fault_addr_in = '0; pc_in = '0;
  endtask

  task automatic push_idle(input string tag, input logic data);
    exp_t e;
    e = '{tag: tag, trap_we: 0, mret_we: 0, rv: 0, flush: 0, stall: 0, busy: 0,
          chk_data: data, pc: 0, mepc: 0, mcause: 0, mtval: 0};
    sb.push_back(e);
  endtask

  task automatic push_trap(input string tag, input logic [31:0] mepc, input logic [31:0] mcause,
                           input logic [31:0] mtval, input logic [31:0] target);
    exp_t e;
    e = '{tag: {tag, "_save"}, trap_we: 1, mret_we: 0, rv: 0, flush: 0, stall: 1, busy: 1,
          chk_data: 1, pc: 0, mepc: mepc, mcause: mcause, mtval: mtval};
    sb.push_back(e);
    e = '{tag: {tag, "_redir"}, trap_we: 0, mret_we: 0, rv: 1, flush: 1, stall: 1, busy: 1,
          chk_data: 0, pc: target, mepc: 0, mcause: 0, mtval: 0};
    sb.push_back(e);
  endtask

  task automatic push_mret(input string tag, input logic [31:0] target);
    exp_t e;
    e = '{tag: {tag, "_ret"}, trap_we: 0, mret_we: 1, rv: 1, flush: 1, stall: 1, busy: 1,
          chk_data: 0, pc: target, mepc: 0, mcause: 0, mtval: 0};
    sb.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_trap_we"}, 32'(trap_we_out), 32'(e.trap_we));
    chk({e.tag, "_mret_we"}, 32'(mret_we_out), 32'(e.mret_we));
    chk({e.tag, "_rv"}, 32'(pc_redirect_valid_out), 32'(e.rv));
    chk({e.tag, "_flush"}, 32'(flush_out), 32'(e.flush));
    chk({e.tag, "_stall"}, 32'(stall_out), 32'(e.stall));
    chk({e.tag, "_busy"}, 32'(busy_out), 32'(e.busy));
    chk({e.tag, "_pc"}, pc_redirect_out, e.pc);
    if (e.chk_data) begin
      chk({e.tag, "_mepc"}, mepc_wdata_out, e.mepc);
      chk({e.tag, "_mcause"}, mcause_wdata_out, e.mcause);
      chk({e.tag, "_mtval"}, mtval_wdata_out, e.mtval);
    end
  endtask

  // Caller has driven the detect-cycle inputs just after a rising edge.
  task automatic run_trap(input string tag, input logic [31:0] mepc, input logic [31:0] mcause,
                          input logic [31:0] mtval, input logic [31:0] target);
    #1;
    chk({tag, "_detect_stall"}, 32'(stall_out), 32'd1);
    chk({tag, "_detect_busy"}, 32'(busy_out), 32'd0);
    push_trap(tag, mepc, mcause, mtval, target);
    tick(); clear_inputs(); check_cycle();
    tick(); check_cycle();
    tick(); push_idle({tag, "_idle"}, 0); check_cycle();
  endtask

  task automatic run_mret(input string tag, input logic [31:0] target);
    #1;
    chk({tag, "_detect_stall"}, 32'(stall_out), 32'd1);
    push_mret(tag, target);
    tick(); clear_inputs(); check_cycle();
    tick(); push_idle({tag, "_idle"}, 0); check_cycle();
  endtask

  initial begin
    clear_inputs();
    mtvec_in = 32'h0000_2000;
    mepc_in  = '0;
    reset = 0;
    #2;
    push_idle("reset", 1); check_cycle();
    tick(); tick();
    reset = 1;
    tick();

    // Direct-mode illegal instruction
    instr_valid_in = 1; pc_in = 32'h40; illegal_instruction_in = 1;
    run_trap("illegal", 32'h40, 32'h2, 32'h0, 32'h2000);

    // Vectored MTI
    mtvec_in = 32'h0000_1001;
    instr_valid_in = 1; pc_in = 32'h80; mstatus_mie_in = 1; mie_in = 12'h080; mip_in = 12'h080;
    run_trap("vec_mti", 32'h80, 32'h8000_0007, 32'h0, 32'h0000_101C);

    // MEI beats MTI and ecall
    instr_valid_in = 1; pc_in = 32'h100; ecall_in = 1; mstatus_mie_in = 1;
    mie_in = 12'h880; mip_in = 12'h880;
    run_trap("prio_mei", 32'h100, 32'h8000_000B, 32'h0, 32'h0000_102C);

    // Same with MIE clear: ecall taken, vectored mode falls back to base
    instr_valid_in = 1; pc_in = 32'h100; ecall_in = 1; mstatus_mie_in = 0;
    mie_in = 12'h880; mip_in = 12'h880;
    run_trap("prio_ecall", 32'h100, 32'h0000_000B, 32'h0, 32'h0000_1000);

    // Misaligned beats illegal, mtval carries fault address
    mtvec_in = 32'h0000_2000;
    instr_valid_in = 1; pc_in = 32'h200; misaligned_in = 1; illegal_instruction_in = 1;
    fault_addr_in = 32'h203;
    run_trap("misaligned", 32'h200, 32'h0, 32'h203, 32'h2000);

    // MRET
    mepc_in = 32'h102;
    instr_valid_in = 1; pc_in = 32'h300; mret_in = 1;
    run_mret("mret", 32'h102);

    // MRET target drops bit 0
    mepc_in = 32'h103;
    instr_valid_in = 1; pc_in = 32'h304; mret_in = 1;
    run_mret("mret_odd", 32'h102);

    // MRET with EBREAK: exception wins
    instr_valid_in = 1; pc_in = 32'h308; mret_in = 1; ebreak_in = 1;
    run_trap("mret_ebreak", 32'h308, 32'h3, 32'h0, 32'h2000);

    // MRET with MSI in mode 11: interrupt wins, non-vectored target
    mtvec_in = 32'h0000_1003;
    instr_valid_in = 1; pc_in = 32'h30C; mret_in = 1; mstatus_mie_in = 1;
    mie_in = 12'h008; mip_in = 12'h008;
    run_trap("mret_msi", 32'h30C, 32'h8000_0003, 32'h0, 32'h1000);

    // Invalid instruction slot is ignored
    mtvec_in = 32'h0000_2000;
    instr_valid_in = 0; pc_in = 32'h400; illegal_instruction_in = 1; mret_in = 1;
    #1; chk("bubble_stall", 32'(stall_out), 32'd0);
    tick(); push_idle("bubble", 0); check_cycle();
    clear_inputs();

    // Reset during SAVE
    instr_valid_in = 1; pc_in = 32'h500; ecall_in = 1;
    tick(); clear_inputs();
    chk("rst_pre_we", 32'(trap_we_out), 32'd1);
    reset = 0;
    #1; push_idle("rst_save", 1); check_cycle();
    tick(); push_idle("rst_hold", 1); check_cycle();
    reset = 1;
    tick(); push_idle("rst_release", 1); check_cycle();

    instr_valid_in = 1; pc_in = 32'h600; ecall_in = 1;
    run_trap("post_rst_ecall", 32'h600, 32'hB, 32'h0, 32'h2000);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
